noc_switch_allocator: RTL
=========================

# noc_switch_allocator

Per-cycle switch allocator for the 5-port NoC router (N, S, E, W, L). Each cycle it takes the head flit of each input FIFO and computes that flit's output direction with XY dimension-order routing. It then arbitrates every output port round-robin among its requesters and tracks downstream credits per output port. Registered outputs drive the input-FIFO pops, the crossbar port selects and the output-port send enables.

## Interface
Port index order everywhere: 0=N, 1=S, 2=E, 3=W, 4=L.

Parameters:
- XCOORD, 0: router X coordinate (4 bits used).
- YCOORD, 0: router Y coordinate (4 bits used).
- CREDITS, 4: downstream buffer depth per output port; initial credit count.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  5  input FIFO head valid, per input port.
- dest_i  in  40  head-flit destination byte, 8 bits per input; input p at [8p+7:8p]; destX=[7:4], destY=[3:0].
- credit_inc_i  in  5  one-cycle pulse per output port: downstream freed one slot.
- pop_o  out  5  registered; pop head of input p.
- send_en_o  out  5  registered; output port o transmits this cycle.
- port_select_o  out  15  registered; 3 bits per output o at [3o+2:3o]; value = granted input index 0..4, or 7 = idle.

## Operation
- Route computation, combinational per input:
  - destX > XCOORD → E; destX < XCOORD → W.
  - Otherwise destY > YCOORD → S; destY < YCOORD → N.
  - Otherwise L.
  - Unsigned 4-bit compares.
- Request: input p requests its routed output when valid_i[p]=1 and pop_o[p]=0. The pop_o mask blocks re-granting a head that is being popped this cycle.
- Output o is eligible when credit[o] > 0.
- Arbitration: per output, a round-robin pointer ptr[o] in 0..4.
  - Search order ptr, ptr+1, …, mod 5; the first requester wins.
  - On grant, ptr[o] ← winner+1 (mod 5). With no grant, ptr[o] is unchanged.
- Each input requests exactly one output, so an input is never granted twice in a cycle. Up to 5 grants per cycle.
- Grant registration, at the edge:
  - pop_o[winner]=1, send_en_o[o]=1, port_select_o[o]=winner.
  - Ungranted outputs: send_en_o=0, select=7. Ungranted inputs: pop=0.
- Credit counters are width $clog2(CREDITS+1), range 0..CREDITS:
  - Grant on o: −1. credit_inc_i[o]: +1. Both in the same cycle: unchanged.
  - Increment at CREDITS saturates; this is a protocol error and is flagged by assertion.
- Loopback (L→L) is legal. Routing never produces a U-turn for N/S/E/W inputs under correct network use; no check is made.

## Timing
- Reset (rst=1 at an edge) sets:
  - pop_o=0, send_en_o=0, port_select_o=15'h7FFF.
  - All ptr=0, all credit=CREDITS.
  - Reset mid-operation drops any pending grant; there is no partial state.
- Latency: request visible in cycle t → pop/send_en/select asserted during cycle t+1. The FIFO shifts at the end of t+1; the crossbar reads the head during t+1.
- Back-to-back: an input held valid with new heads is granted at most every other cycle. This is the pop mask; an input is excluded in the cycle its pop_o is high.
- A credit returned in cycle t is usable by the arbitration in cycle t+1.
- The credit decrement occurs at the same edge that registers the grant, so a port never over-issues.

## Test plan
Bench parameters: XCOORD=1, YCOORD=1, CREDITS=4.
- Reset: hold rst 2 cycles with random inputs → pop_o=0, send_en_o=0, port_select_o=15'h7FFF; credits=4 on all ports. Check via 4 grants then stall on E.
- Single route: valid_i[4]=1, dest L=0x21 at cycle t → at t+1 pop_o=5'b10000, send_en_o=5'b00100, select E=4; other selects 7.
- Route decode: dest 0x01→W, 0x10→N, 0x12→S, 0x11→L, each from input L on an idle router. Each yields send_en on the expected port.
- Round-robin: N, S, W all continuously valid with dest 0x21 → E selects sequence 0,1,3,0,1,3…. No input is granted on consecutive cycles.
- Credit exhaustion: L streams to E with no credit_inc → exactly 4 grants, then send_en_o[2]=0. One credit_inc_i[2] pulse → exactly one further grant, one cycle later.
- Simultaneous credit: credit[E]=1, a grant and credit_inc_i[2] in the same cycle → credit stays 1, and the next cycle is granted again.

Source files
------------

// File: rtl/noc_switch_allocator.sv
// Switch allocator for a 5-port NoC router (N,S,E,W,L): XY route compute,
// per-output round-robin arbitration and downstream credit tracking.
module noc_switch_allocator #(
   parameter int XCOORD  = 0,
   parameter int YCOORD  = 0,
   parameter int CREDITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  valid_i,
   input  logic [39:0] dest_i,
   input  logic [4:0]  credit_inc_i,
   output logic [4:0]  pop_o,
   output logic [4:0]  send_en_o,
   output logic [14:0] port_select_o
);
   localparam int            CW   = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CMAX = CW'(CREDITS);
   localparam logic [3:0]    XC   = 4'(XCOORD);
   localparam logic [3:0]    YC   = 4'(YCOORD);

   logic [4:0]         r_pop;
   logic [4:0]         r_send;
   logic [14:0]        r_sel;
   logic [4:0][2:0]    r_ptr;
   logic [4:0][CW-1:0] r_credit;

   logic [4:0][2:0]    w_route;
   logic [4:0][4:0]    w_req;
   logic [4:0]         w_gnt;
   logic [4:0][2:0]    w_win;
   logic [4:0]         w_pop;

   // XY dimension-order routing; the pop mask keeps a head being popped from re-requesting
   always_comb begin
      w_route = '0;
      w_req   = '0;
      for (int p = 0; p < 5; p++) begin
         if (dest_i[8*p+4 +: 4] > XC)      w_route[p] = 3'd2;
         else if (dest_i[8*p+4 +: 4] < XC) w_route[p] = 3'd3;
         else if (dest_i[8*p +: 4] > YC)   w_route[p] = 3'd1;
         else if (dest_i[8*p +: 4] < YC)   w_route[p] = 3'd0;
         else                              w_route[p] = 3'd4;
      end
      for (int o = 0; o < 5; o++) begin
         for (int p = 0; p < 5; p++) begin
            w_req[o][p] = valid_i[p] & ~r_pop[p] & (w_route[p] == 3'(o));
         end
      end
   end

   always_comb begin
      int idx;
      idx   = 0;
      w_gnt = '0;
      w_win = '0;
      w_pop = '0;
      for (int o = 0; o < 5; o++) begin
         for (int k = 0; k < 5; k++) begin
            idx = int'(r_ptr[o]) + k;
            if (idx >= 5) idx = idx - 5;
            if (!w_gnt[o] && (r_credit[o] != '0) && w_req[o][idx]) begin
               w_gnt[o]   = 1'b1;
               w_win[o]   = 3'(idx);
               w_pop[idx] = 1'b1;
            end
         end
      end
   end

   // Grant registration; credit decrement lands on the same edge as the grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pop    <= '0;
         r_send   <= '0;
         r_sel    <= '1;
         r_ptr    <= '0;
         r_credit <= {5{CMAX}};
      end else begin
         r_pop  <= w_pop;
         r_send <= w_gnt;
         for (int o = 0; o < 5; o++) begin
            r_sel[3*o +: 3] <= w_gnt[o] ? w_win[o] : 3'd7;
            if (w_gnt[o]) r_ptr[o] <= (w_win[o] == 3'd4) ? 3'd0 : w_win[o] + 3'd1;
            case ({w_gnt[o], credit_inc_i[o]})
               2'b10:   r_credit[o] <= r_credit[o] - CW'(1);
               2'b01:   if (r_credit[o] != CMAX) r_credit[o] <= r_credit[o] + CW'(1);
               default: ;
            endcase
         end
      end
   end

   // A returned credit with the counter already full means the neighbour lost count
   for (genvar o = 0; o < 5; o++) begin : g_chk
      a_credit_ovf: assert property (@(posedge clk) disable iff (rst)
         !(credit_inc_i[o] && !w_gnt[o] && (r_credit[o] == CMAX)));
   end

   assign pop_o         = r_pop;
   assign send_en_o     = r_send;
   assign port_select_o = r_sel;
endmodule
